// File: rtl/axi_pwm_multi_if.sv
// AXI4-Lite slave bus bundle for the multi-channel PWM block (32-bit data).
interface axi_pwm_multi_if #(
  parameter int unsigned ADDR_W = 6
) ();
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_pwm_multi.sv
// Multi-channel PWM with AXI4-Lite control; PERIOD/DUTY are shadowed and
// take effect on period wrap so a running waveform never glitches.
module axi_pwm_multi #(
  parameter int unsigned NUM_CH             = 4,
  parameter int unsigned CNT_W              = 16,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic              ACLK,
  input  logic              ARESET,
  axi_pwm_multi_if.slave    s_axi,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              irq
);
  localparam int unsigned IDX_W   = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned NUM_REG = 2 ** IDX_W;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_RESP = 2'd2} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic awready_q, awready_d, bvalid_q, bvalid_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  logic              gen_q, gen_d, irq_en_q, irq_en_d, status_q, status_d, irq_q, irq_d;
  logic [NUM_CH-1:0] chen_q, chen_d, inv_q, inv_d, pwm_q, pwm_d;
  logic [CNT_W-1:0]  period_sh_q, period_sh_d, period_act_q, period_act_d, cnt_q, cnt_d;
  logic [CNT_W-1:0]  duty_sh_q [NUM_CH];
  logic [CNT_W-1:0]  duty_sh_d [NUM_CH];
  logic [CNT_W-1:0]  duty_act_q [NUM_CH];
  logic [CNT_W-1:0]  duty_act_d [NUM_CH];

  logic [31:0]      reg_view [NUM_REG];
  logic [31:0]      wmerged;
  logic [IDX_W-1:0] widx, ridx;
  logic             w_en, wrap, status_clr;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    apply_strb = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) apply_strb[8*b +: 8] = new_v[8*b +: 8];
  endfunction

  assign widx = IDX_W'(s_axi.S_AXI_AWADDR >> 2);
  assign ridx = IDX_W'(s_axi.S_AXI_ARADDR >> 2);
  assign w_en = (w_state_q == W_ACK);

  // Readable image of the register map; unmapped words read as zero.
  always_comb begin
    for (int i = 0; i < NUM_REG; i++) reg_view[i] = '0;
    reg_view[0] = 32'(gen_q) | (32'(chen_q) << 8) | (32'(inv_q) << 16);
    reg_view[1] = 32'(period_sh_q);
    reg_view[2] = 32'(status_q);
    reg_view[3] = 32'(irq_en_q);
    for (int n = 0; n < NUM_CH; n++)
      if (4 + n < NUM_REG) reg_view[4+n] = 32'(duty_sh_q[n]);
  end

  // Write channel FSM.
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) w_state_d = W_ACK;
      W_ACK:   w_state_d = W_RESP;
      W_RESP:  if (s_axi.S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_ACK);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Read channel FSM; data is captured from the register image during ACK.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      R_IDLE:  if (s_axi.S_AXI_ARVALID) r_state_d = R_ACK;
      R_ACK:   begin r_state_d = R_RESP; rdata_d = reg_view[ridx]; end
      R_RESP:  if (s_axi.S_AXI_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_ACK);
    rvalid_d  = (r_state_d == R_RESP);
  end

  // Register writes, shadow transfer, counter and outputs.
  always_comb begin
    gen_d       = gen_q;
    chen_d      = chen_q;
    inv_d       = inv_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    irq_en_d    = irq_en_q;
    wmerged     = apply_strb(reg_view[widx], s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
    status_clr  = w_en && (widx == IDX_W'(2)) && s_axi.S_AXI_WSTRB[0] && s_axi.S_AXI_WDATA[0];
    if (w_en) begin
      if (widx == IDX_W'(0)) begin
        gen_d  = wmerged[0];
        chen_d = wmerged[8 +: NUM_CH];
        inv_d  = wmerged[16 +: NUM_CH];
      end
      if (widx == IDX_W'(1)) period_sh_d = CNT_W'(wmerged);
      if (widx == IDX_W'(3)) irq_en_d = wmerged[0];
      for (int n = 0; n < NUM_CH; n++)
        if (widx == IDX_W'(4 + n)) duty_sh_d[n] = CNT_W'(wmerged);
    end

    wrap         = gen_q && (cnt_q == period_act_q);
    cnt_d        = cnt_q + CNT_W'(1);
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    if (!gen_q || wrap) begin
      cnt_d        = '0;
      period_act_d = period_sh_q;
      duty_act_d   = duty_sh_q;
    end
    // Wrap beats a coincident W1C so no period event is ever lost.
    status_d = (status_q && !status_clr) || wrap;
    irq_d    = status_q && irq_en_q;
    for (int n = 0; n < NUM_CH; n++)
      pwm_d[n] = (gen_q && chen_q[n] && (cnt_q < duty_act_q[n])) ^ inv_q[n];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      awready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      gen_q        <= 1'b0;
      chen_q       <= '0;
      inv_q        <= '0;
      irq_en_q     <= 1'b0;
      status_q     <= 1'b0;
      irq_q        <= 1'b0;
      period_sh_q  <= '0;
      period_act_q <= '0;
      cnt_q        <= '0;
      pwm_q        <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        duty_sh_q[n]  <= '0;
        duty_act_q[n] <= '0;
      end
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      awready_q    <= awready_d;
      bvalid_q     <= bvalid_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      gen_q        <= gen_d;
      chen_q       <= chen_d;
      inv_q        <= inv_d;
      irq_en_q     <= irq_en_d;
      status_q     <= status_d;
      irq_q        <= irq_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
      duty_sh_q    <= duty_sh_d;
      duty_act_q   <= duty_act_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign pwm_o               = pwm_q;
  assign irq                 = irq_q;
endmodule

// File: tb/tb_axi_pwm_multi.sv
// Directed self-checking bench for axi_pwm_multi (NUM_CH=4, CNT_W=16).
module tb_axi_pwm_multi;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned AW     = 6;

  logic              clk, rst;
  logic [NUM_CH-1:0] pwm;
  logic              irq;
  int                checks = 0;
  int                errors = 0;

  axi_pwm_multi_if #(.ADDR_W(AW)) bus ();

  axi_pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .C_S_AXI_ADDR_WIDTH(AW)) dut (
    .ACLK(clk), .ARESET(rst), .s_axi(bus), .pwm_o(pwm), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.S_AXI_AWADDR = addr; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_BVALID && n < 20) begin @(negedge clk); n++; end
    resp = bus.S_AXI_BVALID ? bus.S_AXI_BRESP : 2'bxx;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RVALID ? bus.S_AXI_RRESP : 2'bxx;
  endtask

  // Wait (bounded) for a rising edge of pwm[0], returns at that negedge.
  task automatic find_rise(output bit ok);
    logic prev;
    ok = 1'b0;
    @(negedge clk);
    prev = pwm[0];
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (!prev && pwm[0]) ok = 1'b1;
      prev = pwm[0];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0;
    bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
         bus.S_AXI_RVALID, bus.S_AXI_RDATA, pwm, irq} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdata=%h pwm=%b irq=%b bv=%b rv=%b expected all zero",
               bus.S_AXI_RDATA, pwm, irq, bus.S_AXI_BVALID, bus.S_AXI_RVALID);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pwm, irq} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got pwm=%b irq=%b expected 0/0", pwm, irq);
    end
  endtask

  task automatic test_regs();
    logic [1:0]  r;
    logic [31:0] d;
    logic [31:0] wv [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
    // CTRL keeps bit0, ch_en[3:0] and inv[3:0]; running with PERIOD=1 re-sets STATUS.
    logic [31:0] ev [4] = '{32'h00010F01, 32'h00000001, 32'h00000001, 32'h00000001};
    for (int i = 0; i < 4; i++) begin
      axi_write(AW'(4 * i), wv[i], 4'hF, r);
      checks++;
      if (r !== 2'b00) begin errors++; $display("FAIL wr_resp[%0d]: got %b expected 00", i, r); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(AW'(4 * i), d, r);
      checks++;
      if ({r, d} !== {2'b00, ev[i]}) begin
        errors++;
        $display("FAIL rd_reg[%0d]: got resp=%b data=%h expected 00/%h", i, r, d, ev[i]);
      end
    end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_regs: got %b expected 1", irq); end
    axi_write(AW'(8'h00), 32'h0, 4'hF, r);
    axi_write(AW'(8'h0C), 32'h0, 4'hF, r);
    axi_write(AW'(8'h08), 32'h1, 4'hF, r);
  endtask

  task automatic test_strb_unmapped();
    logic [1:0]  r;
    logic [31:0] d;
    axi_write(AW'(8'h04), 32'h00001234, 4'hF, r);
    axi_write(AW'(8'h04), 32'hAAAA55FF, 4'b0001, r);
    axi_read(AW'(8'h06), d, r);
    checks++;
    if ({r, d} !== {2'b00, 32'h000012FF}) begin
      errors++; $display("FAIL wstrb_lane0: got %b/%h expected 00/000012ff", r, d);
    end
    axi_write(AW'(8'h04), 32'hFFFFFFFF, 4'hF, r);
    axi_read(AW'(8'h04), d, r);
    checks++;
    if (d !== 32'h0000FFFF) begin errors++; $display("FAIL period_zext: got %h expected 0000ffff", d); end
    axi_write(AW'(8'h20), 32'h55, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL oob_wr_resp: got %b expected 00", r); end
    axi_read(AW'(8'h20), d, r);
    checks++;
    if ({r, d} !== 34'h0) begin errors++; $display("FAIL oob_rd: got %b/%h expected 00/0", r, d); end
    axi_read(AW'(8'h3C), d, r);
    checks++;
    if ({r, d} !== 34'h0) begin errors++; $display("FAIL unmapped_rd: got %b/%h expected 00/0", r, d); end
  endtask

  task automatic test_rw_collision();
    logic [1:0]  r;
    logic [31:0] d, rd;
    bit aw_seen, ar_seen, got_r, got_b;
    axi_write(AW'(8'h04), 32'd9, 4'hF, r);
    @(negedge clk);
    bus.S_AXI_AWADDR = AW'(8'h04); bus.S_AXI_WDATA = 32'h77; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARADDR = AW'(8'h04);
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    aw_seen = 0; ar_seen = 0; got_r = 0; got_b = 0; rd = '0;
    for (int k = 0; k < 20 && !(got_r && got_b); k++) begin
      @(negedge clk);
      if (aw_seen) begin bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; end
      if (ar_seen) bus.S_AXI_ARVALID = 1'b0;
      aw_seen = bus.S_AXI_AWREADY;
      ar_seen = bus.S_AXI_ARREADY;
      if (bus.S_AXI_RVALID) begin got_r = 1; rd = bus.S_AXI_RDATA; end
      if (bus.S_AXI_BVALID) got_b = 1;
    end
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    checks++;
    if ({got_r, got_b, rd} !== {1'b1, 1'b1, 32'd9}) begin
      errors++; $display("FAIL rw_same_reg: got r=%b b=%b data=%h expected 1/1/00000009", got_r, got_b, rd);
    end
    axi_read(AW'(8'h04), d, r);
    checks++;
    if (d !== 32'h77) begin errors++; $display("FAIL rw_after: got %h expected 00000077", d); end
  endtask

  task automatic test_pwm_basic();
    logic [1:0] r;
    logic prev;
    int highs, rises, others;
    axi_write(AW'(8'h04), 32'd9, 4'hF, r);
    axi_write(AW'(8'h10), 32'd3, 4'hF, r);
    axi_write(AW'(8'h00), 32'h101, 4'hF, r);
    repeat (5) @(negedge clk);
    highs = 0; rises = 0; others = 0;
    prev = pwm[0];
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (pwm[0]) highs++;
      if (!prev && pwm[0]) rises++;
      if (pwm[3:1] !== 3'b000) others++;
      prev = pwm[0];
    end
    checks++;
    if (highs !== 9) begin errors++; $display("FAIL pwm_highs: got %0d expected 9", highs); end
    checks++;
    if (rises !== 3) begin errors++; $display("FAIL pwm_periods: got %0d expected 3", rises); end
    checks++;
    if (others !== 0) begin errors++; $display("FAIL pwm_disabled_ch: got %0d expected 0", others); end
  endtask

  task automatic test_duty_update();
    logic [1:0] r;
    logic smp [30];
    bit   ok, exp_v;
    int   bad;
    find_rise(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL duty_find_rise: got timeout expected edge"); end
    fork
      begin
        smp[0] = pwm[0];
        for (int k = 1; k < 30; k++) begin @(negedge clk); smp[k] = pwm[0]; end
      end
      begin
        repeat (2) @(negedge clk);
        axi_write(AW'(8'h10), 32'd7, 4'hF, r);
      end
    join
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      exp_v = (k <= 2) || (k >= 10 && k <= 16) || (k >= 20 && k <= 26);
      if (smp[k] !== exp_v) bad++;
    end
    checks++;
    if (bad !== 0 || r !== 2'b00) begin
      errors++; $display("FAIL duty_update: got %0d wrong samples resp=%b expected 0/00", bad, r);
    end
  endtask

  task automatic test_edge_duty();
    logic [1:0] r;
    int b1, b2, b3;
    axi_write(AW'(8'h14), 32'd0, 4'hF, r);
    axi_write(AW'(8'h18), 32'd20, 4'hF, r);
    axi_write(AW'(8'h04), 32'd9, 4'hF, r);
    axi_write(AW'(8'h00), 32'h00020701, 4'hF, r);
    repeat (25) @(negedge clk);
    b1 = 0; b2 = 0; b3 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pwm[1] !== 1'b1) b1++;
      if (pwm[2] !== 1'b1) b2++;
      if (pwm[3] !== 1'b0) b3++;
    end
    checks++;
    if (b1 !== 0) begin errors++; $display("FAIL duty0_inverted: got %0d bad expected 0", b1); end
    checks++;
    if (b2 !== 0) begin errors++; $display("FAIL duty_over_period: got %0d bad expected 0", b2); end
    checks++;
    if (b3 !== 0) begin errors++; $display("FAIL ch3_disabled: got %0d bad expected 0", b3); end
  endtask

  task automatic test_period_zero();
    logic [1:0]  r;
    logic [31:0] d;
    int bad;
    axi_write(AW'(8'h04), 32'd0, 4'hF, r);
    axi_write(AW'(8'h10), 32'd1, 4'hF, r);
    repeat (25) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (pwm[0] !== 1'b1) bad++; end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL p0_duty1_high: got %0d bad expected 0", bad); end
    axi_write(AW'(8'h08), 32'd1, 4'hF, r);
    axi_read(AW'(8'h08), d, r);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL p0_status_every_cycle: got %h expected 1", d); end
    axi_write(AW'(8'h10), 32'd0, 4'hF, r);
    repeat (5) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (pwm[0] !== 1'b0) bad++; end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL p0_duty0_low: got %0d bad expected 0", bad); end
  endtask

  task automatic test_irq();
    logic [1:0] r;
    bit ok;
    axi_write(AW'(8'h04), 32'd9, 4'hF, r);
    axi_write(AW'(8'h10), 32'd3, 4'hF, r);
    axi_write(AW'(8'h00), 32'h101, 4'hF, r);
    axi_write(AW'(8'h0C), 32'd1, 4'hF, r);
    repeat (25) @(negedge clk);
    find_rise(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL irq_find_rise: got timeout expected edge"); end
    // Index k negedges after the rise; counter is (k+1) mod 10, wrap cycle at k=8.
    bus.S_AXI_AWADDR = AW'(8'h08); bus.S_AXI_WDATA = 32'd1; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_BREADY = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 1 || k == 7 || k == 12) begin bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; end
      if (k == 3 || k == 9 || k == 14) begin bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; end
      if (k == 6) begin
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b expected 0", irq); end
      end
      if (k == 11) begin
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b expected 1", irq); end
      end
      if (k == 16) begin
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_later_clear: got %b expected 0", irq); end
      end
      if (k == 21) begin
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_wrap: got %b expected 1", irq); end
      end
    end
  endtask

  task automatic test_reset_midtx();
    logic [1:0]  r;
    logic [31:0] d;
    int n;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_AWADDR = AW'(8'h0C); bus.S_AXI_WDATA = 32'd1; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.S_AXI_BVALID !== 1'b1) begin errors++; $display("FAIL bvalid_held: got %b expected 1", bus.S_AXI_BVALID); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.S_AXI_BVALID, pwm, irq} !== '0) begin
      errors++; $display("FAIL async_reset: got bv=%b pwm=%b irq=%b expected 0", bus.S_AXI_BVALID, pwm, irq);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    axi_write(AW'(8'h00), 32'h101, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL post_rst_wr: got %b expected 00", r); end
    axi_read(AW'(8'h00), d, r);
    checks++;
    if ({r, d} !== {2'b00, 32'h101}) begin errors++; $display("FAIL post_rst_rd: got %b/%h expected 00/00000101", r, d); end
    axi_read(AW'(8'h0C), d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL irq_en_reset: got %h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_strb_unmapped();
    test_rw_collision();
    test_pwm_basic();
    test_duty_update();
    test_edge_duty();
    test_period_zero();
    test_irq();
    test_reset_midtx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
